sys_array_stream_host: RTL

- Host-side controller at the far end of the systolic fetcher interface. It drives load_params, start_comp, input_data_a and input_data_b into the fetcher, and consumes its ready and out_data.
- Converts a word-serial valid/ready input stream into the parallel matrices B and A.
- Sequences parameter load and computation, waits for the result, then streams the W×W result matrix back out with backpressure.

---
 rtl/sys_array_stream_host.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sys_array_stream_host.sv
// sys_array_stream_host
//
// Host-side controller for the systolic fetcher. It collects a word-serial
// valid/ready stream into the B and A matrices, pulses load_params and
// start_comp into the fetcher, waits for the result, then streams the
// ARRAY_W x ARRAY_W result matrix back out with backpressure.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   s_valid/s_ready     input word handshake; s_data carries B words, then A words
//   reuse_b             sampled in IDLE; skip the B load if B is already loaded
//   m_valid/m_ready     result word handshake; m_data is one result element,
//                       m_last marks the final element of a job
//   busy                high whenever the controller is not idle
//   load_params         one-cycle pulse after B is complete
//   start_comp          one-cycle pulse after A is complete
//   input_data_a/_b     matrices A and B; element [r][c] at flat index r*ARRAY_L+c
//   res_ready           fetcher result ready (sticky in the fetcher)
//   res_data            fetcher result; element [r][c] at flat index r*ARRAY_W+c
//
// Every output comes straight from a register. Output registers are loaded
// from the next state, so each output is aligned with the state it belongs to.
module sys_array_stream_host #(
  parameter int DATA_WIDTH   = 8,
  parameter int ARRAY_W      = 4,
  parameter int ARRAY_L      = 4,
  // Must not exceed 65535; the wait counter is 16 bits wide.
  parameter int COMP_LATENCY = ARRAY_L + 2*ARRAY_W + 4
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [DATA_WIDTH-1:0]                   s_data,
  input  logic                                    reuse_b,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [2*DATA_WIDTH-1:0]                 m_data,
  output logic                                    m_last,
  output logic                                    busy,
  output logic                                    load_params,
  output logic                                    start_comp,
  output logic [ARRAY_W*ARRAY_L*DATA_WIDTH-1:0]   input_data_a,
  output logic [ARRAY_W*ARRAY_L*DATA_WIDTH-1:0]   input_data_b,
  input  logic                                    res_ready,
  input  logic [ARRAY_W*ARRAY_W*2*DATA_WIDTH-1:0] res_data
);

  localparam int NIN    = ARRAY_W * ARRAY_L;
  localparam int NOUT   = ARRAY_W * ARRAY_W;
  localparam int NMAX   = (NIN > NOUT) ? NIN : NOUT;
  localparam int IDX_W  = $clog2(NMAX + 1);
  localparam int RES_EW = 2 * DATA_WIDTH;
  localparam int MAT_W  = NIN * DATA_WIDTH;
  localparam int RES_W  = NOUT * RES_EW;

  localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(NIN - 1);
  localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(NOUT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [15:0]      CNT_INIT = 16'(COMP_LATENCY);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    PARAM  = 3'd2,
    LOAD_A = 3'd3,
    START  = 3'd4,
    WAIT   = 3'd5,
    UNLOAD = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 b_loaded_q, b_loaded_d;
  logic [MAT_W-1:0]     a_q, a_d;
  logic [MAT_W-1:0]     b_q, b_d;
  logic [RES_W-1:0]     res_q, res_d;

  logic                 s_ready_q, s_ready_d;
  logic                 m_valid_q, m_valid_d;
  logic [RES_EW-1:0]    m_data_q, m_data_d;
  logic                 m_last_q, m_last_d;
  logic                 busy_q, busy_d;
  logic                 load_params_q, load_params_d;
  logic                 start_comp_q, start_comp_d;

  logic                 hs_in;
  logic                 hs_out;

  assign hs_in  = s_valid & s_ready_q;
  assign hs_out = m_valid_q & m_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    b_loaded_d = b_loaded_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;

    case (state_q)
      IDLE: begin
        // Only decides which matrix to fill; the word itself is taken once
        // s_ready is up in the load state.
        if (s_valid) begin
          state_d = (reuse_b && b_loaded_q) ? LOAD_A : LOAD_B;
        end
      end
      LOAD_B: begin
        if (hs_in) begin
          b_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = s_data;
          if (idx_q == LAST_IN) begin
            idx_d   = '0;
            state_d = PARAM;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      PARAM: begin
        b_loaded_d = 1'b1;
        state_d    = LOAD_A;
      end
      LOAD_A: begin
        if (hs_in) begin
          a_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = s_data;
          if (idx_q == LAST_IN) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      START: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        // res_ready is sticky in the fetcher and may still be high from the
        // previous job, so it is only trusted once the counter has expired.
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (res_ready) begin
          res_d   = res_data;
          idx_d   = '0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (hs_out) begin
          if (idx_q == LAST_OUT) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output registers follow the next state so they line up with it.
    s_ready_d     = (state_d == LOAD_B) || (state_d == LOAD_A);
    m_valid_d     = (state_d == UNLOAD);
    busy_d        = (state_d != IDLE);
    load_params_d = (state_d == PARAM);
    start_comp_d  = (state_d == START);
    m_data_d      = '0;
    m_last_d      = 1'b0;
    if (state_d == UNLOAD) begin
      // Re-reads the same element while stalled, so m_data holds.
      m_data_d = res_d[idx_d*RES_EW +: RES_EW];
      m_last_d = (idx_d == LAST_OUT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      b_loaded_q    <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      s_ready_q     <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      busy_q        <= 1'b0;
      load_params_q <= 1'b0;
      start_comp_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      b_loaded_q    <= b_loaded_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_q         <= res_d;
      s_ready_q     <= s_ready_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      busy_q        <= busy_d;
      load_params_q <= load_params_d;
      start_comp_q  <= start_comp_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign busy         = busy_q;
  assign load_params  = load_params_q;
  assign start_comp   = start_comp_q;
  assign input_data_a = a_q;
  assign input_data_b = b_q;

endmodule
